// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 4;

  // Read-mode selectors for the FWFT parameter.
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Bits needed to hold any value 0..max_val (a depth of 16 needs 5 bits).
  function automatic int count_w(input int max_val);
    int w;
    w = 1;
    while ((2 ** w) <= max_val) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage is deliberately not reset; only accepted writes change it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with selectable FWFT read mode, occupancy
// count, almost-full/almost-empty thresholds and sticky error flags.
//
// Handshake: a push is taken at a rising edge when wr_en=1 and full=0; a pop
// is taken when rd_en=1 and empty=0. full/empty act as the not-ready flags and
// come from registered pointers only, so wr_en/rd_en never combinationally
// affect any output. In registered mode rd_valid pulses for the single cycle
// after an accepted pop; in FWFT mode rd_valid means "rd_data is the head word"
// and rd_en acknowledges (pops) it.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int FWFT      = FWFT_OFF,
  parameter int AFULL_TH  = (2 ** ADDR_W) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = count_w(DEPTH);

  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W + 1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W + 1)'(AEMPTY_TH);

  // Reject threshold settings that would make a flag meaningless.
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_sync_param: AFULL_TH must lie in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_sync_param: AEMPTY_TH must lie in 0..DEPTH-1");
  end
  if (CNT_W != ADDR_W + 1) begin : g_bad_cnt_w
    $error("fifo_sync_param: count width does not match ADDR_W+1");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   occ;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] ram_q;

  assign occ    = wptr - rptr;
  assign full   = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                  (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty  = (wptr == rptr);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  assign count        = occ;
  assign almost_full  = (occ >= AFULL_C);
  assign almost_empty = (occ <= AEMPTY_C);

  // Advance each pointer on its own accepted operation; both may move at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_acc) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !clr_err) || (wr_en && full);
      underflow <= (underflow && !clr_err) || (rd_en && empty);
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (wr_acc),
    .wr_addr (wptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_addr (rptr[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    // Head word is always on display; reading it while a write lands elsewhere is safe.
    assign rd_data  = ram_q;
    assign rd_valid = !empty;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Capture the head word on an accepted pop and flag it for one cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= ram_q;
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: three instances (8x16 registered, 8x16 FWFT,
// 32x8 registered) checked every cycle against a queue-based model, plus
// directed sequences with literal expectations.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int W = 32;
  localparam int M_DEPTH  [3] = '{16, 16, 8};
  localparam int M_FWFT   [3] = '{0, 1, 0};
  localparam int M_AFULL  [3] = '{14, 14, 6};
  localparam int M_AEMPTY [3] = '{2, 2, 2};
  localparam logic [W-1:0] M_MASK [3] = '{32'h0000_00FF, 32'h0000_00FF, 32'hFFFF_FFFF};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT hookup ----------------
  logic         i_wr  [3];
  logic         i_rd  [3];
  logic         i_clr [3];
  logic [W-1:0] i_wd  [3];

  logic [7:0]   rdd0, rdd1;
  logic [31:0]  rdd2;
  logic [4:0]   cnt0, cnt1;
  logic [3:0]   cnt2;
  logic         o_rdv [3];
  logic         o_full [3];
  logic         o_empty [3];
  logic         o_af [3];
  logic         o_ae [3];
  logic         o_ovf [3];
  logic         o_udf [3];

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(2)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(i_wr[0]), .wr_data(i_wd[0][7:0]), .rd_en(i_rd[0]),
    .rd_data(rdd0), .rd_valid(o_rdv[0]), .full(o_full[0]), .empty(o_empty[0]),
    .almost_full(o_af[0]), .almost_empty(o_ae[0]), .count(cnt0),
    .overflow(o_ovf[0]), .underflow(o_udf[0]), .clr_err(i_clr[0])
  );

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(2)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(i_wr[1]), .wr_data(i_wd[1][7:0]), .rd_en(i_rd[1]),
    .rd_data(rdd1), .rd_valid(o_rdv[1]), .full(o_full[1]), .empty(o_empty[1]),
    .almost_full(o_af[1]), .almost_empty(o_ae[1]), .count(cnt1),
    .overflow(o_ovf[1]), .underflow(o_udf[1]), .clr_err(i_clr[1])
  );

  fifo_sync_param #(.DATA_W(32), .ADDR_W(3), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(i_wr[2]), .wr_data(i_wd[2]), .rd_en(i_rd[2]),
    .rd_data(rdd2), .rd_valid(o_rdv[2]), .full(o_full[2]), .empty(o_empty[2]),
    .almost_full(o_af[2]), .almost_empty(o_ae[2]), .count(cnt2),
    .overflow(o_ovf[2]), .underflow(o_udf[2]), .clr_err(i_clr[2])
  );

  function automatic logic [W-1:0] get_rdd(int id);
    case (id)
      0:       return W'(rdd0);
      1:       return W'(rdd1);
      default: return rdd2;
    endcase
  endfunction

  function automatic logic [W-1:0] get_cnt(int id);
    case (id)
      0:       return W'(cnt0);
      1:       return W'(cnt1);
      default: return W'(cnt2);
    endcase
  endfunction

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  function automatic int q_size(int id);
    case (id)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [W-1:0] q_head(int id);
    case (id)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  function automatic void q_push(int id, logic [W-1:0] v);
    case (id)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic void q_pop(int id);
    case (id)
      0:       void'(exp_q0.pop_front());
      1:       void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endfunction

  function automatic void q_clear(int id);
    case (id)
      0:       exp_q0.delete();
      1:       exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endfunction

  logic [W-1:0] m_rdd [3] = '{32'h0, 32'h0, 32'h0};
  logic         m_rdv [3] = '{1'b0, 1'b0, 1'b0};
  logic         m_ovf [3] = '{1'b0, 1'b0, 1'b0};
  logic         m_udf [3] = '{1'b0, 1'b0, 1'b0};
  int           m_n;
  logic         m_wacc, m_racc;
  logic [W-1:0] m_v;

  // Behavioural model: a queue per FIFO, updated from the inputs seen at each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int id = 0; id < 3; id++) begin
        q_clear(id);
        m_rdd[id] <= '0;
        m_rdv[id] <= 1'b0;
        m_ovf[id] <= 1'b0;
        m_udf[id] <= 1'b0;
      end
    end else begin
      for (int id = 0; id < 3; id++) begin
        m_n    = q_size(id);
        m_wacc = i_wr[id] && (m_n != M_DEPTH[id]);
        m_racc = i_rd[id] && (m_n != 0);
        if (m_racc) begin
          m_v = q_head(id);
          q_pop(id);
          if (M_FWFT[id] == 0) m_rdd[id] <= m_v;
        end
        m_rdv[id] <= m_racc && (M_FWFT[id] == 0);
        if (m_wacc) q_push(id, i_wd[id] & M_MASK[id]);
        m_ovf[id] <= (m_ovf[id] && !i_clr[id]) || (i_wr[id] && (m_n == M_DEPTH[id]));
        m_udf[id] <= (m_udf[id] && !i_clr[id]) || (i_rd[id] && (m_n == 0));
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(string name, int id, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [fifo%0d] t=%0t: got %0h expected %0h", name, id, $time, act, exp);
    end
  endtask

  int c_n;

  // Compare every output of every instance against the model on the falling edge.
  always @(negedge clk) begin
    for (int id = 0; id < 3; id++) begin
      c_n = q_size(id);
      chk("count",        id, get_cnt(id),  W'(c_n));
      chk("empty",        id, W'(o_empty[id]), W'(c_n == 0));
      chk("full",         id, W'(o_full[id]),  W'(c_n == M_DEPTH[id]));
      chk("almost_full",  id, W'(o_af[id]),    W'(c_n >= M_AFULL[id]));
      chk("almost_empty", id, W'(o_ae[id]),    W'(c_n <= M_AEMPTY[id]));
      chk("overflow",     id, W'(o_ovf[id]),   W'(m_ovf[id]));
      chk("underflow",    id, W'(o_udf[id]),   W'(m_udf[id]));
      if (M_FWFT[id] != 0) begin
        chk("rd_valid", id, W'(o_rdv[id]), W'(c_n != 0));
        if (c_n != 0) chk("rd_data", id, get_rdd(id), q_head(id));
      end else begin
        chk("rd_valid", id, W'(o_rdv[id]), W'(m_rdv[id]));
        chk("rd_data",  id, get_rdd(id),   m_rdd[id]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(int id, bit w, logic [W-1:0] d, bit r, bit c);
    i_wr[id]  = w;
    i_wd[id]  = d & M_MASK[id];
    i_rd[id]  = r;
    i_clr[id] = c;
    @(posedge clk);
    #2;
    i_wr[id]  = 1'b0;
    i_rd[id]  = 1'b0;
    i_clr[id] = 1'b0;
  endtask

  task automatic rand_cycle(int wr_pct);
    for (int id = 0; id < 3; id++) begin
      i_wr[id]  = ($urandom_range(0, 99) < wr_pct);
      i_rd[id]  = ($urandom_range(0, 99) < (100 - wr_pct));
      i_clr[id] = ($urandom_range(0, 99) < 5);
      i_wd[id]  = $urandom & M_MASK[id];
    end
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int id = 0; id < 3; id++) begin
      i_wr[id] = 1'b0; i_rd[id] = 1'b0; i_clr[id] = 1'b0; i_wd[id] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Reset values
    chk("rst_count",  0, get_cnt(0), 0);
    chk("rst_empty",  0, W'(o_empty[0]), 1);
    chk("rst_full",   0, W'(o_full[0]), 0);
    chk("rst_aempty", 0, W'(o_ae[0]), 1);
    chk("rst_afull",  0, W'(o_af[0]), 0);
    chk("rst_rdv",    0, W'(o_rdv[0]), 0);
    chk("rst_rdd",    0, get_rdd(0), 0);

    // Fill with 0x00..0x0F, watching thresholds, then overflow with 0xAA
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1'b1, W'(k - 1), 1'b0, 1'b0);
      chk("fill_count", 0, get_cnt(0), W'(k));
      chk("fill_afull", 0, W'(o_af[0]), W'(k >= 14));
      chk("fill_aempty", 0, W'(o_ae[0]), W'(k <= 2));
    end
    chk("full_set", 0, W'(o_full[0]), 1);
    drive(0, 1'b1, 32'hAA, 1'b0, 1'b0);
    chk("ovf_full",  0, W'(o_full[0]), 1);
    chk("ovf_count", 0, get_cnt(0), 16);
    chk("ovf_flag",  0, W'(o_ovf[0]), 1);
    for (int k = 0; k < 16; k++) begin
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      chk("drain_data",  0, get_rdd(0), W'(k));
      chk("drain_valid", 0, W'(o_rdv[0]), 1);
    end
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    chk("idle_valid", 0, W'(o_rdv[0]), 0);
    chk("idle_hold",  0, get_rdd(0), 32'h0F);
    chk("idle_empty", 0, W'(o_empty[0]), 1);
    chk("ovf_sticky", 0, W'(o_ovf[0]), 1);
    drive(0, 1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 0, W'(o_ovf[0]), 0);

    // Simultaneous read/write at count 1 returns the old head
    drive(0, 1'b1, 32'h11, 1'b0, 1'b0);
    drive(0, 1'b1, 32'h22, 1'b1, 1'b0);
    chk("rw_data",  0, get_rdd(0), 32'h11);
    chk("rw_count", 0, get_cnt(0), 1);
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    chk("rw_next",  0, get_rdd(0), 32'h22);
    chk("rw_empty", 0, W'(o_empty[0]), 1);

    // Underflow, then reset mid-stream after 5 writes
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    chk("udf_set", 0, W'(o_udf[0]), 1);
    for (int k = 0; k < 5; k++) drive(0, 1'b1, W'(8'h30 + k), 1'b0, 1'b0);
    chk("pre_rst_count", 0, get_cnt(0), 5);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("mid_rst_count", 0, get_cnt(0), 0);
    chk("mid_rst_empty", 0, W'(o_empty[0]), 1);
    chk("mid_rst_rdv",   0, W'(o_rdv[0]), 0);
    chk("mid_rst_ovf",   0, W'(o_ovf[0]), 0);
    chk("mid_rst_udf",   0, W'(o_udf[0]), 0);
    rst = 1'b0;
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_udf", 0, W'(o_udf[0]), 1);
    drive(0, 1'b0, '0, 1'b1, 1'b1);
    chk("set_wins", 0, W'(o_udf[0]), 1);
    drive(0, 1'b0, '0, 1'b0, 1'b1);
    chk("udf_clr", 0, W'(o_udf[0]), 0);

    // FWFT: written word is visible the next cycle, popping empties it
    chk("fwft_idle_rdv", 1, W'(o_rdv[1]), 0);
    drive(1, 1'b1, 32'h5A, 1'b0, 1'b0);
    chk("fwft_data",  1, get_rdd(1), 32'h5A);
    chk("fwft_valid", 1, W'(o_rdv[1]), 1);
    chk("fwft_nempty", 1, W'(o_empty[1]), 0);
    drive(1, 1'b0, '0, 1'b1, 1'b0);
    chk("fwft_pop_empty", 1, W'(o_empty[1]), 1);
    chk("fwft_pop_valid", 1, W'(o_rdv[1]), 0);

    // Random push/pop on all three, alternating fill-biased and drain-biased phases
    for (int c = 0; c < 600; c++) begin
      rand_cycle(((c / 40) % 2 == 0) ? 75 : 25);
    end
    for (int id = 0; id < 3; id++) begin
      i_wr[id] = 1'b0; i_rd[id] = 1'b0; i_clr[id] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
